// File: rtl/cache_ctrl.sv
// Miss-handling controller between a CPU load/store port and a 256-line x 4-word cache array.
// Handles write-back of dirty victims, word-by-word refill, replay, and saturating hit/miss counters.
module cache_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   // CPU port
   input  logic             cpu_req,
   input  logic             cpu_wr,
   input  logic [14:0]      cpu_addr,
   input  logic [15:0]      cpu_wdata,
   output logic [15:0]      cpu_rdata,
   output logic             cpu_done,
   output logic             cpu_busy,
   // cache array control
   output logic             c_enable,
   output logic             c_comp,
   output logic             c_write,
   output logic             c_valid_in,
   output logic [7:0]       c_index,
   output logic [1:0]       c_word,
   output logic [4:0]       c_tag_in,
   output logic [15:0]      c_data_in,
   input  logic             c_hit,
   input  logic             c_dirty,
   input  logic             c_valid,
   input  logic [4:0]       c_tag_out,
   input  logic [15:0]      c_data_out,
   // main memory port
   output logic             mem_req,
   output logic             mem_wr,
   output logic [14:0]      mem_addr,
   output logic [15:0]      mem_wdata,
   input  logic [15:0]      mem_rdata,
   input  logic             mem_ack,
   // statistics / status
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count,
   output logic             err
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_COMPARE  = 3'd1;
   localparam logic [2:0] S_WB       = 3'd2;
   localparam logic [2:0] S_FILL_REQ = 3'd3;
   localparam logic [2:0] S_FILL_WR  = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [14:0]      addr_q, addr_d;
   logic             wr_q, wr_d;
   logic [15:0]      wdata_q, wdata_d;
   logic [4:0]       victim_tag_q, victim_tag_d;
   logic [1:0]       word_q, word_d;
   logic [15:0]      fill_buf_q, fill_buf_d;
   logic             replay_q, replay_d;
   logic             cpu_done_q, cpu_done_d;
   logic [15:0]      cpu_rdata_q, cpu_rdata_d;
   logic [CNT_W-1:0] hit_q, hit_d;
   logic [CNT_W-1:0] miss_q, miss_d;
   logic             err_q, err_d;

   logic [4:0] req_tag;
   logic [7:0] req_index;

   assign req_tag   = addr_q[14:10];
   assign req_index = addr_q[9:2];

   always_comb begin
      // NOTE: every combinational output and next-state gets a default here so no path infers a latch.
      state_d      = state_q;
      addr_d       = addr_q;
      wr_d         = wr_q;
      wdata_d      = wdata_q;
      victim_tag_d = victim_tag_q;
      word_d       = word_q;
      fill_buf_d   = fill_buf_q;
      replay_d     = replay_q;
      cpu_done_d   = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      hit_d        = hit_q;
      miss_d       = miss_q;
      err_d        = err_q;

      c_enable   = 1'b0;
      c_comp     = 1'b0;
      c_write    = 1'b0;
      c_valid_in = 1'b0;
      c_index    = req_index;
      c_word     = addr_q[1:0];
      c_tag_in   = req_tag;
      c_data_in  = wdata_q;

      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;

      case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               addr_d  = cpu_addr;
               wr_d    = cpu_wr;
               wdata_d = cpu_wdata;
               state_d = S_COMPARE;
            end
         end

         S_COMPARE: begin
            c_enable = 1'b1;
            c_comp   = 1'b1;
            c_write  = wr_q;
            if (c_hit && c_valid) begin
               cpu_rdata_d = c_data_out;
               cpu_done_d  = 1'b1;
               replay_d    = 1'b0;
               state_d     = S_IDLE;
               // The replay after a refill completes the original miss; it is not a hit.
               if (!replay_q && (hit_q != '1)) hit_d = hit_q + CNT_W'(1);
            end else if (replay_q) begin
               err_d       = 1'b1;
               cpu_rdata_d = c_data_out;
               cpu_done_d  = 1'b1;
               replay_d    = 1'b0;
               state_d     = S_IDLE;
            end else begin
               victim_tag_d = c_tag_out;
               word_d       = 2'd0;
               if (miss_q != '1) miss_d = miss_q + CNT_W'(1);
               state_d = (c_valid && c_dirty) ? S_WB : S_FILL_REQ;
            end
         end

         S_WB: begin
            c_enable  = 1'b1;
            c_word    = word_q;
            mem_req   = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = {victim_tag_q, req_index, word_q};
            mem_wdata = c_data_out;
            if (mem_ack) begin
               // word_q wraps 3 -> 0, which is where the refill starts.
               word_d = word_q + 2'd1;
               if (word_q == 2'd3) state_d = S_FILL_REQ;
            end
         end

         S_FILL_REQ: begin
            mem_req  = 1'b1;
            mem_addr = {req_tag, req_index, word_q};
            if (mem_ack) begin
               fill_buf_d = mem_rdata;
               state_d    = S_FILL_WR;
            end
         end

         S_FILL_WR: begin
            c_enable   = 1'b1;
            c_write    = 1'b1;
            c_valid_in = 1'b1;
            c_word     = word_q;
            c_data_in  = fill_buf_q;
            word_d     = word_q + 2'd1;
            if (word_q == 2'd3) begin
               replay_d = 1'b1;
               state_d  = S_COMPARE;
            end else begin
               state_d = S_FILL_REQ;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         wr_q         <= 1'b0;
         wdata_q      <= '0;
         victim_tag_q <= '0;
         word_q       <= '0;
         fill_buf_q   <= '0;
         replay_q     <= 1'b0;
         cpu_done_q   <= 1'b0;
         cpu_rdata_q  <= '0;
         hit_q        <= '0;
         miss_q       <= '0;
         err_q        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q      <= state_d;
         addr_q       <= addr_d;
         wr_q         <= wr_d;
         wdata_q      <= wdata_d;
         victim_tag_q <= victim_tag_d;
         word_q       <= word_d;
         fill_buf_q   <= fill_buf_d;
         replay_q     <= replay_d;
         cpu_done_q   <= cpu_done_d;
         cpu_rdata_q  <= cpu_rdata_d;
         hit_q        <= hit_d;
         miss_q       <= miss_d;
         err_q        <= err_d;
      end
   end

   assign cpu_busy   = (state_q != S_IDLE);
   assign cpu_done   = cpu_done_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign hit_count  = hit_q;
   assign miss_count = miss_q;
   assign err        = err_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural cache array and memory, reference cache/memory model feeding
// scoreboard queues, a table of request vectors, and hand sequences for reset, latency and saturation.
module tb_cache_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_wr;
   logic [14:0] cpu_addr;
   logic [15:0] cpu_wdata, cpu_rdata;
   logic        cpu_done, cpu_busy;
   logic        c_enable, c_comp, c_write, c_valid_in;
   logic [7:0]  c_index;
   logic [1:0]  c_word;
   logic [4:0]  c_tag_in, c_tag_out;
   logic [15:0] c_data_in, c_data_out;
   logic        c_hit, c_dirty, c_valid;
   logic        mem_req, mem_wr, mem_ack;
   logic [14:0] mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic [15:0] hit_count, miss_count;
   logic        err;

   // second instance with narrow counters and a cache that always hits
   logic        cpu_req2;
   logic [14:0] cpu_addr2;
   logic [15:0] cpu_rdata2;
   logic        cpu_done2, cpu_busy2;
   logic        c_enable2, c_comp2, c_write2, c_valid_in2;
   logic [7:0]  c_index2;
   logic [1:0]  c_word2;
   logic [4:0]  c_tag_in2;
   logic [15:0] c_data_in2;
   logic        mem_req2, mem_wr2;
   logic [14:0] mem_addr2;
   logic [15:0] mem_wdata2;
   logic [1:0]  hit_count2, miss_count2;
   logic        err2;

   always #5 clk = ~clk;

   cache_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_busy(cpu_busy),
      .c_enable(c_enable), .c_comp(c_comp), .c_write(c_write), .c_valid_in(c_valid_in),
      .c_index(c_index), .c_word(c_word), .c_tag_in(c_tag_in), .c_data_in(c_data_in),
      .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid), .c_tag_out(c_tag_out),
      .c_data_out(c_data_out),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .hit_count(hit_count), .miss_count(miss_count), .err(err)
   );

   cache_ctrl #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req2), .cpu_wr(1'b0), .cpu_addr(cpu_addr2), .cpu_wdata(16'h0000),
      .cpu_rdata(cpu_rdata2), .cpu_done(cpu_done2), .cpu_busy(cpu_busy2),
      .c_enable(c_enable2), .c_comp(c_comp2), .c_write(c_write2), .c_valid_in(c_valid_in2),
      .c_index(c_index2), .c_word(c_word2), .c_tag_in(c_tag_in2), .c_data_in(c_data_in2),
      .c_hit(1'b1), .c_dirty(1'b0), .c_valid(1'b1), .c_tag_out(5'd0),
      .c_data_out(16'hA5A5),
      .mem_req(mem_req2), .mem_wr(mem_wr2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
      .mem_rdata(16'h0000), .mem_ack(1'b0),
      .hit_count(hit_count2), .miss_count(miss_count2), .err(err2)
   );

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] init_word(input int a);
      return 16'(a * 7) ^ 16'h3C5A;
   endfunction

   // ---------------- cache array model (same-cycle lookup) ----------------
   bit [4:0]  ct_tag   [256];
   bit        ct_val   [256];
   bit        ct_dirty [256];
   bit [15:0] ct_data  [256][4];

   assign c_tag_out  = ct_tag[c_index];
   assign c_valid    = ct_val[c_index];
   assign c_dirty    = ct_dirty[c_index];
   assign c_data_out = ct_data[c_index][c_word];
   assign c_hit      = c_comp && ct_val[c_index] && (ct_tag[c_index] == c_tag_in);

   always @(posedge clk) begin
      if (c_enable && c_write) begin
         if (c_comp) begin
            if (c_hit) begin
               ct_data[c_index][c_word] <= c_data_in;
               ct_dirty[c_index]        <= 1'b1;
            end
         end else begin
            ct_data[c_index][c_word] <= c_data_in;
            ct_tag[c_index]          <= c_tag_in;
            ct_val[c_index]          <= c_valid_in;
            ct_dirty[c_index]        <= 1'b0;
         end
      end
   end

   // ---------------- main memory model ----------------
   logic [15:0] mem [32768];
   int ack_delay = 0;
   int wait_cnt  = 0;
   bit hs_seen   = 1'b0;
   int xfer_cnt  = 0;

   always @(posedge clk) begin
      #1;
      if (hs_seen) begin
         hs_seen  = 1'b0;
         wait_cnt = 0;
      end
      if (rst || !mem_req) begin
         mem_ack  = 1'b0;
         wait_cnt = 0;
      end else begin
         mem_ack   = (wait_cnt >= ack_delay);
         mem_rdata = mem[mem_addr];
         wait_cnt++;
      end
   end

   // ---------------- reference model and scoreboard ----------------
   typedef struct {
      bit          wr;
      logic [14:0] addr;
      logic [15:0] data;
   } mem_exp_t;

   typedef struct {
      bit          is_load;
      logic [15:0] data;
   } done_exp_t;

   mem_exp_t    exp_mem[$];
   done_exp_t   exp_done[$];
   logic [15:0] cpu_view [32768];
   bit          ref_val   [256];
   bit [4:0]    ref_tag   [256];
   bit          ref_dirty [256];

   task automatic push_expect(input bit wr, input logic [14:0] a, input logic [15:0] d);
      logic [7:0]  idx;
      logic [4:0]  tg;
      logic [14:0] va;
      idx = a[9:2];
      tg  = a[14:10];
      if (!(ref_val[idx] && ref_tag[idx] == tg)) begin
         if (ref_val[idx] && ref_dirty[idx]) begin
            for (int k = 0; k < 4; k++) begin
               va = {ref_tag[idx], idx, 2'(k)};
               exp_mem.push_back('{1'b1, va, cpu_view[va]});
            end
         end
         for (int k = 0; k < 4; k++) exp_mem.push_back('{1'b0, {tg, idx, 2'(k)}, 16'h0000});
         ref_val[idx]   = 1'b1;
         ref_tag[idx]   = tg;
         ref_dirty[idx] = 1'b0;
      end
      if (wr) begin
         cpu_view[a]    = d;
         ref_dirty[idx] = 1'b1;
      end
      exp_done.push_back('{!wr, cpu_view[a]});
   endtask

   // Monitors sample on the falling edge, half a cycle away from the DUT's active edge.
   bit          stall_prev = 1'b0;
   logic [14:0] st_addr;
   logic        st_wr;
   logic [15:0] st_wdata;

   always @(negedge clk) begin
      mem_exp_t  me;
      done_exp_t de;
      if (rst) begin
         stall_prev = 1'b0;
         hs_seen    = 1'b0;
      end else begin
         if (mem_req) begin
            if (stall_prev) begin
               check("stall_mem_addr", 32'(mem_addr), 32'(st_addr));
               check("stall_mem_wr", 32'(mem_wr), 32'(st_wr));
               check("stall_mem_wdata", 32'(mem_wdata), 32'(st_wdata));
            end
            if (mem_ack) begin
               stall_prev = 1'b0;
               hs_seen    = 1'b1;
               xfer_cnt++;
               if (exp_mem.size() == 0) begin
                  check("unexpected_mem_xfer", 32'(mem_addr), 32'h7FFF_FFFF);
               end else begin
                  me = exp_mem.pop_front();
                  check("mem_addr", 32'(mem_addr), 32'(me.addr));
                  check("mem_wr", 32'(mem_wr), 32'(me.wr));
                  if (me.wr) check("mem_wdata", 32'(mem_wdata), 32'(me.data));
               end
               if (mem_wr) mem[mem_addr] = mem_wdata;
            end else begin
               stall_prev = 1'b1;
               st_addr    = mem_addr;
               st_wr      = mem_wr;
               st_wdata   = mem_wdata;
            end
         end else begin
            stall_prev = 1'b0;
         end
         if (cpu_done) begin
            if (exp_done.size() == 0) begin
               check("unexpected_cpu_done", 32'(cpu_done), 32'h0);
            end else begin
               de = exp_done.pop_front();
               if (de.is_load) check("cpu_rdata", 32'(cpu_rdata), 32'(de.data));
            end
         end
      end
   end

   // ---------------- request driver ----------------
   task automatic do_req(input bit wr, input logic [14:0] a, input logic [15:0] d);
      bit got;
      push_expect(wr, a, d);
      @(negedge clk);
      cpu_req   = 1'b1;
      cpu_wr    = wr;
      cpu_addr  = a;
      cpu_wdata = d;
      @(posedge clk);
      #1;
      // Keep a bogus request active with garbage fields while busy; it must have no effect.
      cpu_wr    = 1'($urandom);
      cpu_addr  = 15'($urandom);
      cpu_wdata = 16'($urandom);
      got = 1'b0;
      for (int n = 0; n < 400 && !got; n++) begin
         @(negedge clk);
         if (cpu_done) begin
            cpu_req = 1'b0;
            got     = 1'b1;
         end
      end
      if (!got) begin
         cpu_req = 1'b0;
         check("cpu_done_timeout", 32'(got), 32'h1);
      end
      #1;
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      bit          wr;
      logic [14:0] addr;
      logic [15:0] wdata;
      int          delay;
      int          exp_hits;
      int          exp_miss;
      int          exp_xfers;
   } vec_t;

   localparam int NV = 11;
   vec_t vec [NV];

   initial begin
      bit          got;
      bit          sv_val, sv_dirty;
      bit [4:0]    sv_tag;
      int          x0;

      vec[0]  = '{1'b0, 15'h0A5C, 16'h0000, 0, 0, 1, 4};  // cold load
      vec[1]  = '{1'b0, 15'h0A5C, 16'h0000, 0, 1, 1, 0};  // hit
      vec[2]  = '{1'b1, 15'h0A5C, 16'hBEEF, 0, 2, 1, 0};  // store hit, line dirty
      vec[3]  = '{1'b0, 15'h0E5C, 16'h0000, 0, 2, 2, 8};  // conflict: write back + fill
      vec[4]  = '{1'b1, 15'h0E5E, 16'h1234, 0, 3, 2, 0};  // store hit
      vec[5]  = '{1'b0, 15'h0A5D, 16'h0000, 5, 3, 3, 8};  // slow memory, dirty victim
      vec[6]  = '{1'b0, 15'h0A5D, 16'h0000, 0, 4, 3, 0};  // hit on refilled line
      vec[7]  = '{1'b0, 15'h0E5E, 16'h0000, 2, 4, 4, 4};  // clean victim, data from write-back
      vec[8]  = '{1'b1, 15'h7FFF, 16'h5555, 0, 4, 5, 4};  // store miss at top address
      vec[9]  = '{1'b0, 15'h7FFF, 16'h0000, 0, 5, 5, 0};  // read back replayed store
      vec[10] = '{1'b0, 15'h0000, 16'h0000, 0, 5, 6, 4};  // bottom address

      for (int i = 0; i < 32768; i++) begin
         mem[i]      = init_word(i);
         cpu_view[i] = init_word(i);
      end

      rst       = 1'b1;
      cpu_req   = 1'b0;
      cpu_wr    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      cpu_req2  = 1'b0;
      cpu_addr2 = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cpu_done", 32'(cpu_done), 32'h0);
      check("rst_cpu_busy", 32'(cpu_busy), 32'h0);
      check("rst_mem_req", 32'(mem_req), 32'h0);
      check("rst_c_enable", 32'(c_enable), 32'h0);
      check("rst_hit_count", 32'(hit_count), 32'h0);
      check("rst_miss_count", 32'(miss_count), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         ack_delay = vec[i].delay;
         x0 = xfer_cnt;
         do_req(vec[i].wr, vec[i].addr, vec[i].wdata);
         check($sformatf("v%0d_hit_count", i), 32'(hit_count), 32'(vec[i].exp_hits));
         check($sformatf("v%0d_miss_count", i), 32'(miss_count), 32'(vec[i].exp_miss));
         check($sformatf("v%0d_xfers", i), 32'(xfer_cnt - x0), 32'(vec[i].exp_xfers));
         check($sformatf("v%0d_pending_mem", i), 32'(exp_mem.size()), 32'h0);
         check($sformatf("v%0d_err", i), 32'(err), 32'h0);
      end
      check("wb_word0_beef", 32'(mem[15'h0A5C]), 32'h0000_BEEF);
      check("wb_0e5e_1234", 32'(mem[15'h0E5E]), 32'h0000_1234);

      // Reset while the first fill request is waiting for its ack.
      sv_val   = ref_val[8'h10];
      sv_tag   = ref_tag[8'h10];
      sv_dirty = ref_dirty[8'h10];
      ack_delay = 4;
      push_expect(1'b0, 15'h1441, 16'h0000);
      @(negedge clk);
      cpu_req  = 1'b1;
      cpu_wr   = 1'b0;
      cpu_addr = 15'h1441;
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (mem_req) got = 1'b1;
      end
      check("rstmid_reached_fill", 32'(got), 32'h1);
      check("rstmid_fill_is_read", 32'(mem_wr), 32'h0);
      #2;
      rst = 1'b1;
      #1;
      check("rstmid_mem_req", 32'(mem_req), 32'h0);
      check("rstmid_busy", 32'(cpu_busy), 32'h0);
      check("rstmid_hit_count", 32'(hit_count), 32'h0);
      check("rstmid_miss_count", 32'(miss_count), 32'h0);
      check("rstmid_c_enable", 32'(c_enable), 32'h0);
      exp_mem.delete();
      exp_done.delete();
      ref_val[8'h10]   = sv_val;
      ref_tag[8'h10]   = sv_tag;
      ref_dirty[8'h10] = sv_dirty;
      @(negedge clk);
      rst = 1'b0;
      ack_delay = 0;
      x0 = xfer_cnt;
      do_req(1'b0, 15'h1441, 16'h0000);
      check("rerun_xfers", 32'(xfer_cnt - x0), 32'h4);
      check("rerun_miss_count", 32'(miss_count), 32'h1);
      check("rerun_hit_count", 32'(hit_count), 32'h0);

      // Hit latency: request sampled at edge n, done visible during cycle n+2, no memory traffic.
      push_expect(1'b0, 15'h1441, 16'h0000);
      @(negedge clk);
      cpu_req  = 1'b1;
      cpu_addr = 15'h1441;
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      @(negedge clk);
      check("lat_n1_done", 32'(cpu_done), 32'h0);
      check("lat_n1_busy", 32'(cpu_busy), 32'h1);
      check("lat_n1_mem_req", 32'(mem_req), 32'h0);
      @(negedge clk);
      check("lat_n2_done", 32'(cpu_done), 32'h1);
      check("lat_n2_busy", 32'(cpu_busy), 32'h0);
      check("lat_n2_mem_req", 32'(mem_req), 32'h0);
      #1;
      check("lat_hit_count", 32'(hit_count), 32'h1);
      @(negedge clk);
      check("after_done_low", 32'(cpu_done), 32'h0);

      // Narrow counters saturate at 3.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         cpu_req2  = 1'b1;
         cpu_addr2 = 15'(i * 4);
         @(posedge clk);
         #1;
         cpu_req2 = 1'b0;
         got = 1'b0;
         for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (cpu_done2) got = 1'b1;
         end
         check($sformatf("sat%0d_done", i), 32'(got), 32'h1);
         check($sformatf("sat%0d_rdata", i), 32'(cpu_rdata2), 32'h0000_A5A5);
         check($sformatf("sat%0d_hit_count", i), 32'(hit_count2), (i >= 2) ? 32'h3 : 32'(i + 1));
      end
      check("sat_miss_count", 32'(miss_count2), 32'h0);
      check("sat_err", 32'(err2), 32'h0);
      check("sat_mem_req", 32'(mem_req2), 32'h0);

      check("final_err", 32'(err), 32'h0);
      check("final_pending_done", 32'(exp_done.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
